calc_sequencer: RTL and testbench



---
 rtl/calc_pkg.sv | 72 +++++++
 rtl/calc_sequencer_bin2bcd.sv | 71 +++++++
 rtl/calc_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the keypad calculator sequencer.
//   - raw key-code constants (row*4+col)
//   - calc_state_t (sequencer states), calc_op_t (latched operator)
//   - key_kind_t / key_t and decode_key(), which classifies a raw key code
package calc_pkg;

  localparam logic [4:0] KEY_D1    = 5'd0;
  localparam logic [4:0] KEY_D2    = 5'd1;
  localparam logic [4:0] KEY_D3    = 5'd2;
  localparam logic [4:0] KEY_PLUS  = 5'd3;
  localparam logic [4:0] KEY_D4    = 5'd4;
  localparam logic [4:0] KEY_D5    = 5'd5;
  localparam logic [4:0] KEY_D6    = 5'd6;
  localparam logic [4:0] KEY_EQUAL = 5'd7;
  localparam logic [4:0] KEY_D7    = 5'd8;
  localparam logic [4:0] KEY_D8    = 5'd9;
  localparam logic [4:0] KEY_D9    = 5'd10;
  localparam logic [4:0] KEY_MINUS = 5'd11;
  localparam logic [4:0] KEY_D0    = 5'd13;
  localparam logic [4:0] KEY_CLEAR = 5'd15;

  typedef enum logic [1:0] {
    ST_ENTER_A,
    ST_ENTER_B,
    ST_SHOW,
    ST_CONVERT
  } calc_state_t;

  typedef enum logic {
    OP_ADD,
    OP_SUB
  } calc_op_t;

  typedef enum logic [2:0] {
    K_NONE,
    K_DIGIT,
    K_PLUS,
    K_MINUS,
    K_EQUAL,
    K_CLEAR
  } key_kind_t;

  typedef struct packed {
    key_kind_t  kind;
    logic [3:0] digit;
  } key_t;

  function automatic key_t decode_key(input logic [4:0] code);
    key_t k;
    k.kind  = K_DIGIT;
    k.digit = 4'd0;
    case (code)
      KEY_D1:    k.digit = 4'd1;
      KEY_D2:    k.digit = 4'd2;
      KEY_D3:    k.digit = 4'd3;
      KEY_D4:    k.digit = 4'd4;
      KEY_D5:    k.digit = 4'd5;
      KEY_D6:    k.digit = 4'd6;
      KEY_D7:    k.digit = 4'd7;
      KEY_D8:    k.digit = 4'd8;
      KEY_D9:    k.digit = 4'd9;
      KEY_D0:    k.digit = 4'd0;
      KEY_PLUS:  k.kind  = K_PLUS;
      KEY_MINUS: k.kind  = K_MINUS;
      KEY_EQUAL: k.kind  = K_EQUAL;
      KEY_CLEAR: k.kind  = K_CLEAR;
      default:   k.kind  = K_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/calc_sequencer_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
// Ports:
//   clk_in, rst    clock, synchronous active-high reset
//   start          load bin_in (one-cycle pulse)
//   bin_in         binary value, WIDTH bits
//   done           result valid (held until the next clock edge)
//   bcd_out        BCD result, 4*DIGITS bits, MS digit highest
// Timing: load on the start edge, WIDTH shift edges, done high after the
// last shift so the consumer captures one edge later.
module bin2bcd_seq #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                run_q, run_d;

  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    // add-3 correction on every digit >= 5 before the shift
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    if (start) begin
      bin_d = bin_in;
      bcd_d = '0;
      cnt_d = CW'(WIDTH);
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        {bcd_d, bin_d} = {adj[4*DIGITS-2:0], bin_q, 1'b0};
        cnt_d = cnt_q - 1'b1;
      end else begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done    = run_q && (cnt_q == '0);
  assign bcd_out = bcd_q;

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad calculator control core. Accepts key events,
// sequences operand entry, add/subtract and BCD conversion for display.
// Ports:
//   clk_in, rst          clock, synchronous active-high reset
//   key_valid/key_code   key event in (raw code row*4+col)
//   key_ready            key can be accepted (= !busy)
//   bcd_out, disp_valid  displayed BCD value and its one-cycle update pulse
//   overflow, negative   result flags
//   busy                 conversion in progress
// Macro CALC_SUB_EN: builds the MINUS key path and the negative flag;
// without it code 11 is ignored and negative is tied to 0.
//
// state      | meaning
// ST_ENTER_A | entering first operand
// ST_ENTER_B | entering second operand, operator latched
// ST_SHOW    | result displayed
// ST_CONVERT | BCD conversion running, returns to ret_q
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 3
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [4:0]          key_code,
  output logic                key_ready,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                disp_valid,
  output logic                overflow,
  output logic                negative,
  output logic                busy
);

  localparam int LIMIT = 10**DIGITS - 1;

  calc_state_t         state_q, state_d, ret_q, ret_d, launch_ret;
  logic [WIDTH-1:0]    acc_q, acc_d, cur_q, cur_d, result_q, result_d;
  logic [WIDTH-1:0]    conv_val_q, conv_val_d, launch_val;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, conv_bcd;
  logic                ovf_q, ovf_d, neg_q, neg_d;
  logic                busy_q, busy_d, start_q, start_d, disp_q, disp_d;
  logic                launch, conv_done;
  key_t                key;
  key_kind_t           kind;
  logic [WIDTH+3:0]    entry;
  logic [WIDTH:0]      sum, raw;

  assign sum = {1'b0, acc_q} + {1'b0, cur_q};

`ifdef CALC_SUB_EN
  calc_op_t       op_q, op_d;
  logic [WIDTH:0] diff, sub_mag;
  logic           sub_neg;

  assign diff     = {1'b0, acc_q} - {1'b0, cur_q};
  assign sub_neg  = diff[WIDTH];
  assign sub_mag  = sub_neg ? -diff : diff;
  assign raw      = (op_q == OP_SUB) ? sub_mag : sum;
  assign negative = neg_q;
`else
  assign raw      = sum;
  assign negative = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    acc_d      = acc_q;
    cur_d      = cur_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    neg_d      = neg_q;
    busy_d     = busy_q;
    start_d    = 1'b0;
    conv_val_d = conv_val_q;
    bcd_d      = bcd_q;
    disp_d     = 1'b0;
`ifdef CALC_SUB_EN
    op_d       = op_q;
`endif
    launch     = 1'b0;
    launch_val = '0;
    launch_ret = ST_ENTER_A;
    key        = decode_key(key_code);
    kind       = key.kind;
`ifndef CALC_SUB_EN
    if (kind == K_MINUS) kind = K_NONE;
`endif
    entry = (WIDTH+4)'(cur_q) * (WIDTH+4)'(10) + (WIDTH+4)'(key.digit);

    case (state_q)
      ST_CONVERT: begin
        if (conv_done) begin
          bcd_d   = conv_bcd;
          disp_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ret_q;
        end
      end
      default: begin
        if (key_valid) begin
          case (kind)
            K_CLEAR: begin
              acc_d    = '0;
              cur_d    = '0;
              result_d = '0;
              ovf_d    = 1'b0;
              neg_d    = 1'b0;
`ifdef CALC_SUB_EN
              op_d     = OP_ADD;
`endif
              launch   = 1'b1;
            end
            K_DIGIT: begin
              if (state_q == ST_SHOW) begin
                acc_d      = '0;
                ovf_d      = 1'b0;
                neg_d      = 1'b0;
                cur_d      = WIDTH'(key.digit);
                launch     = 1'b1;
                launch_val = WIDTH'(key.digit);
              end else if (entry <= (WIDTH+4)'(LIMIT)) begin
                cur_d      = entry[WIDTH-1:0];
                launch     = 1'b1;
                launch_val = entry[WIDTH-1:0];
                launch_ret = state_q;
              end
            end
            K_PLUS, K_MINUS: begin
              if (state_q == ST_ENTER_A ||
                  (state_q == ST_SHOW && !ovf_q && !neg_q)) begin
                acc_d      = (state_q == ST_SHOW) ? result_q : cur_q;
                cur_d      = '0;
                launch     = 1'b1;
                launch_ret = ST_ENTER_B;
              end
`ifdef CALC_SUB_EN
              if (state_q == ST_ENTER_B || launch)
                op_d = (kind == K_MINUS) ? OP_SUB : OP_ADD;
`endif
            end
            K_EQUAL: begin
              if (state_q == ST_ENTER_B) begin
                ovf_d      = raw > (WIDTH+1)'(LIMIT);
`ifdef CALC_SUB_EN
                neg_d      = (op_q == OP_SUB) && sub_neg;
`else
                neg_d      = 1'b0;
`endif
                result_d   = ovf_d ? WIDTH'(LIMIT) : raw[WIDTH-1:0];
                launch     = 1'b1;
                launch_val = result_d;
                launch_ret = ST_SHOW;
              end
            end
            default: ;
          endcase
        end
      end
    endcase

    if (launch) begin
      state_d    = ST_CONVERT;
      ret_d      = launch_ret;
      busy_d     = 1'b1;
      start_d    = 1'b1;
      conv_val_d = launch_val;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= ST_ENTER_A;
      ret_q      <= ST_ENTER_A;
      acc_q      <= '0;
      cur_q      <= '0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      neg_q      <= 1'b0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      conv_val_q <= '0;
      bcd_q      <= '0;
      disp_q     <= 1'b0;
`ifdef CALC_SUB_EN
      op_q       <= OP_ADD;
`endif
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      acc_q      <= acc_d;
      cur_q      <= cur_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      neg_q      <= neg_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      conv_val_q <= conv_val_d;
      bcd_q      <= bcd_d;
      disp_q     <= disp_d;
`ifdef CALC_SUB_EN
      op_q       <= op_d;
`endif
    end
  end

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_bin2bcd (
    .clk_in  (clk_in),
    .rst     (rst),
    .start   (start_q),
    .bin_in  (conv_val_q),
    .done    (conv_done),
    .bcd_out (conv_bcd)
  );

  assign key_ready  = !busy_q;
  assign busy       = busy_q;
  assign bcd_out    = bcd_q;
  assign disp_valid = disp_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [4:0]  key_code = 5'd0;
  logic        key_ready;
  logic [11:0] bcd_out;
  logic        disp_valid;
  logic        overflow;
  logic        negative;
  logic        busy;

  int total = 0;
  int bad = 0;

  calc_sequencer #(.WIDTH(10), .DIGITS(3)) dut (
    .clk_in     (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .bcd_out    (bcd_out),
    .disp_valid (disp_valid),
    .overflow   (overflow),
    .negative   (negative),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Presents one key; lat = edges from accept to disp_valid, 0 if no
  // conversion launched, -1 if disp_valid never came.
  task automatic press(input logic [4:0] code, output int lat);
    int w;
    lat = 0;
    w = 0;
    @(negedge clk);
    while (!key_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!key_ready) begin
      total++;
      bad++;
      $display("FAIL press_ready: key_ready=%b required 1", key_ready);
    end
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    if (busy) begin
      lat = -1;
      for (int n = 1; n <= 30; n++) begin
        @(posedge clk);
        #1;
        if (disp_valid) begin
          lat = n;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    int dv = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (disp_valid) dv++;
    end
    total++; if (dv !== 0) begin bad++; $display("FAIL reset_disp: pulses=%0d required 0", dv); end
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b required 1", key_ready); end
    total++; if (bcd_out !== 12'h000) begin bad++; $display("FAIL reset_bcd: got %h required 000", bcd_out); end
    total++; if (overflow !== 1'b0 || negative !== 1'b0) begin bad++; $display("FAIL reset_flags: got %b%b required 00", overflow, negative); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
  endtask

  task automatic test_add();
    logic [4:0]  codes [6] = '{5'd0, 5'd1, 5'd3, 5'd2, 5'd4, 5'd7};
    logic [11:0] expv  [6] = '{12'h001, 12'h012, 12'h000, 12'h003, 12'h034, 12'h046};
    int lat;
    for (int i = 0; i < 6; i++) begin
      press(codes[i], lat);
      total++; if (lat !== 12) begin bad++; $display("FAIL add_lat[%0d]: got %0d required 12", i, lat); end
      total++; if (bcd_out !== expv[i]) begin bad++; $display("FAIL add_bcd[%0d]: got %h required %h", i, bcd_out, expv[i]); end
    end
    total++; if (dut.state_q !== ST_SHOW) begin bad++; $display("FAIL add_state: got %0d required %0d", dut.state_q, ST_SHOW); end
  endtask

  task automatic test_digit_limit();
    int lat;
    press(5'd15, lat);
    total++; if (bcd_out !== 12'h000) begin bad++; $display("FAIL lim_clear: got %h required 000", bcd_out); end
    for (int i = 0; i < 3; i++) begin
      press(5'd10, lat);
      total++; if (lat !== 12) begin bad++; $display("FAIL lim_lat[%0d]: got %0d required 12", i, lat); end
    end
    total++; if (bcd_out !== 12'h999) begin bad++; $display("FAIL lim_999: got %h required 999", bcd_out); end
    press(5'd10, lat);
    total++; if (lat !== 0) begin bad++; $display("FAIL lim_drop: lat=%0d required 0", lat); end
    total++; if (bcd_out !== 12'h999 || busy !== 1'b0) begin bad++; $display("FAIL lim_hold: bcd=%h busy=%b required 999/0", bcd_out, busy); end
  endtask

  task automatic test_overflow();
    int lat;
    press(5'd3, lat);
    total++; if (bcd_out !== 12'h000) begin bad++; $display("FAIL ovf_plus: got %h required 000", bcd_out); end
    for (int i = 0; i < 3; i++) press(5'd10, lat);
    press(5'd7, lat);
    total++; if (lat !== 12) begin bad++; $display("FAIL ovf_lat: got %0d required 12", lat); end
    total++; if (overflow !== 1'b1 || negative !== 1'b0) begin bad++; $display("FAIL ovf_flags: got %b%b required 10", overflow, negative); end
    total++; if (bcd_out !== 12'h999) begin bad++; $display("FAIL ovf_clamp: got %h required 999", bcd_out); end
    press(5'd3, lat);
    total++; if (lat !== 0 || dut.state_q !== ST_SHOW) begin bad++; $display("FAIL ovf_chain: lat=%0d state=%0d required 0/%0d", lat, dut.state_q, ST_SHOW); end
    press(5'd15, lat);
    total++; if (bcd_out !== 12'h000 || overflow !== 1'b0 || negative !== 1'b0) begin bad++; $display("FAIL ovf_clear: bcd=%h flags=%b%b required 000/00", bcd_out, overflow, negative); end
  endtask

  task automatic test_sub();
    int lat;
    press(5'd15, lat);
    press(5'd5, lat);
`ifdef CALC_SUB_EN
    press(5'd11, lat);
    total++; if (lat !== 12 || bcd_out !== 12'h000) begin bad++; $display("FAIL sub_minus: lat=%0d bcd=%h required 12/000", lat, bcd_out); end
    press(5'd9, lat);
    press(5'd7, lat);
    total++; if (negative !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL sub_flags: got %b%b required 01", overflow, negative); end
    total++; if (bcd_out !== 12'h003) begin bad++; $display("FAIL sub_bcd: got %h required 003", bcd_out); end
    press(5'd3, lat);
    total++; if (lat !== 0) begin bad++; $display("FAIL sub_chain: lat=%0d required 0", lat); end
    press(5'd0, lat);
    total++; if (negative !== 1'b0 || bcd_out !== 12'h001) begin bad++; $display("FAIL sub_digit: neg=%b bcd=%h required 0/001", negative, bcd_out); end
`else
    press(5'd11, lat);
    total++; if (lat !== 0) begin bad++; $display("FAIL nosub_minus: lat=%0d required 0", lat); end
    press(5'd9, lat);
    total++; if (bcd_out !== 12'h058) begin bad++; $display("FAIL nosub_entry: got %h required 058", bcd_out); end
    press(5'd7, lat);
    total++; if (lat !== 0 || negative !== 1'b0 || bcd_out !== 12'h058) begin bad++; $display("FAIL nosub_equal: lat=%0d neg=%b bcd=%h required 0/0/058", lat, negative, bcd_out); end
`endif
  endtask

  task automatic test_chain();
    int lat;
    press(5'd15, lat);
    press(5'd1, lat);
    press(5'd3, lat);
    press(5'd2, lat);
    press(5'd7, lat);
    total++; if (bcd_out !== 12'h005) begin bad++; $display("FAIL chain_first: got %h required 005", bcd_out); end
    press(5'd3, lat);
    total++; if (lat !== 12 || bcd_out !== 12'h000) begin bad++; $display("FAIL chain_op: lat=%0d bcd=%h required 12/000", lat, bcd_out); end
    press(5'd4, lat);
    press(5'd7, lat);
    total++; if (bcd_out !== 12'h009) begin bad++; $display("FAIL chain_result: got %h required 009", bcd_out); end
    press(5'd12, lat);
    total++; if (lat !== 0 || bcd_out !== 12'h009) begin bad++; $display("FAIL chain_ignored: lat=%0d bcd=%h required 0/009", lat, bcd_out); end
    press(5'd8, lat);
    total++; if (bcd_out !== 12'h007 || dut.state_q !== ST_ENTER_A) begin bad++; $display("FAIL chain_newdigit: bcd=%h state=%0d required 007/%0d", bcd_out, dut.state_q, ST_ENTER_A); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int lowbusy = 0;
    press(5'd15, lat);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 5'd0;
    @(posedge clk);
    #1;
    key_code = 5'd1;
    for (int n = 1; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (!busy || key_ready || disp_valid) lowbusy++;
    end
    total++; if (lowbusy !== 0) begin bad++; $display("FAIL b2b_busy: bad cycles=%0d required 0", lowbusy); end
    @(posedge clk);
    #1;
    total++; if (disp_valid !== 1'b1 || key_ready !== 1'b1 || bcd_out !== 12'h001) begin bad++; $display("FAIL b2b_first: dv=%b rdy=%b bcd=%h required 1/1/001", disp_valid, key_ready, bcd_out); end
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: busy=%b required 1", busy); end
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (disp_valid) begin
        lat = n;
        break;
      end
    end
    total++; if (lat !== 12 || bcd_out !== 12'h012) begin bad++; $display("FAIL b2b_second: lat=%0d bcd=%h required 12/012", lat, bcd_out); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int dv = 0;
    press(5'd15, lat);
    press(5'd4, lat);
    total++; if (bcd_out !== 12'h004) begin bad++; $display("FAIL rmid_pre: got %h required 004", bcd_out); end
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 5'd5;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy: got %b required 1", busy); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bcd_out !== 12'h000 || busy !== 1'b0 || key_ready !== 1'b1 || disp_valid !== 1'b0) begin bad++; $display("FAIL rmid_vals: bcd=%h busy=%b rdy=%b dv=%b required 000/0/1/0", bcd_out, busy, key_ready, disp_valid); end
    rst = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (disp_valid) dv++;
    end
    total++; if (dv !== 0) begin bad++; $display("FAIL rmid_nopulse: pulses=%0d required 0", dv); end
    press(5'd0, lat);
    total++; if (lat !== 12 || bcd_out !== 12'h001) begin bad++; $display("FAIL rmid_after: lat=%0d bcd=%h required 12/001", lat, bcd_out); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_digit_limit();
    test_overflow();
    test_sub();
    test_chain();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
